font_rom_arbiter: RTL
=====================

Name: font_rom_arbiter

Overview:
- Shares one single-port, fixed-latency font/character ROM between two text-overlay requesters in the ctl_text path.
- Arbitrates round-robin, one access per clock.
- Registers the ROM address/enable and carries a valid+requester-ID tag through an internal shift pipeline matched to ROM latency.
- Each response comes back flagged to the requester that issued it, aligned with the pixel pipeline at a fixed, known latency.

Parameters:
- AW, 12: ROM address width.
- DW, 8: ROM data width.
- ROM_LAT, 1: clock cycles from rom_en/rom_addr sampled by the ROM to rom_data valid. Legal range ROM_LAT >= 1; values < 1 are a configuration error, flagged by an elaboration-time check.

Ports:
- clk  in  1  posedge clock (pixel clock domain).
- rst  in  1  reset, synchronous, active-high.
- req0  in  1  requester 0 access request; held until gnt0.
- addr0  in  AW  requester 0 ROM address; valid while req0=1.
- gnt0  out  1  combinational grant to requester 0.
- req1  in  1  requester 1 access request.
- addr1  in  AW  requester 1 ROM address.
- gnt1  out  1  combinational grant to requester 1.
- rom_en  out  1  registered ROM read enable.
- rom_addr  out  AW  registered ROM address.
- rom_data  in  DW  ROM read data; valid ROM_LAT cycles after rom_en.
- rsp_valid0  out  1  registered response strobe for requester 0, one cycle wide.
- rsp_valid1  out  1  registered response strobe for requester 1.
- rsp_data  out  DW  registered response data, shared; qualified by rsp_valid0/1.
- busy  out  1  high while any access is in flight (rom_en or any tag stage valid).

Behaviour:
- Clock and reset: all state on posedge clk; reset is rst, synchronous, active-high.
- Reset values: rom_en=0, rom_addr=0, rsp_valid0/1=0, rsp_data=0, busy=0. All tag stages cleared. RR pointer last=1, so requester 0 wins the first tie.
- Arbitration (combinational, cycle N):
  - Only req0 high: gnt0=1.
  - Only req1 high: gnt1=1.
  - Both high: grant the requester != last.
  - Neither high: no grant.
  - gnt0 and gnt1 are never both 1.
  - gnt is 0 during any cycle with rst=1.
- Pointer: on the edge ending a granted cycle, last <= granted ID. Unchanged on idle cycles.
- Handshake:
  - A request is consumed in the cycle gnt is high.
  - The requester may present a new address or hold req high the next cycle; back-to-back grants to the same requester are allowed when the other is idle.
  - The arbiter does not check address stability; holding addr while req is high and ungranted is the requester's obligation.
- Issue (edge ending cycle N):
  - rom_en <= any grant.
  - rom_addr <= granted address, or holds its previous value when there is no grant.
- Tag pipeline:
  - ROM_LAT+1 stages of {valid, id}.
  - Stage 0 loads {any_grant, granted_id} at the same edge as rom_en.
  - Each stage shifts every clock, with no stall.
- Response:
  - When the last tag stage is valid, at the next edge: rsp_data <= rom_data, rsp_valid<id> <= 1, the other rsp_valid <= 0.
  - Otherwise both rsp_valid <= 0, and rsp_data holds its value.
- Latency: gnt in cycle N → rom_en high in N+1 → rom_data in N+1+ROM_LAT → rsp_valid high in N+2+ROM_LAT. Total ROM_LAT+2, constant.
- Throughput: 1 access/clock sustained. Responses return in grant order.
- busy = rom_en OR any tag stage valid (combinational from registers).
- Reset mid-operation: all in-flight tags are discarded with no response, and rsp_valid0/1 are 0 from the first cycle after the reset edge. After rst deasserts, arbitration restarts with last=1.

Test Plan:
- Reset value check, ROM_LAT=2: assert rst 3 cycles, then release → gnt0/1, rom_en, rsp_valid0/1, rsp_data, busy all 0; first tie grants req0.
- Single access, ROM_LAT=2, ROM modelled as 2-cycle pipe returning data=addr[7:0]^8'hA5: req0 with addr0=12'h041 for one cycle N → gnt0 in N, rom_en=1 and rom_addr=12'h041 in N+1, rsp_valid0=1 and rsp_data=8'hE4 in N+4 only, rsp_valid1=0 throughout.
- Contention, ROM_LAT=2: req0 and req1 held high for 6 cycles, addr0=12'h010, addr1=12'h020 → grants alternate 0,1,0,1,0,1; rsp_valid alternates 0,1,0,1,0,1 starting 4 cycles after the first grant; rsp_data alternates 8'hB5/8'h85.
- Single-requester streaming: req1 alone for 5 cycles, addr1 = 1,2,3,4,5 → gnt1=1 every cycle; 5 consecutive rsp_valid1 pulses with data A4,A7,A6,A1,A0; busy high continuously from first rom_en until the last response.
- Reset mid-flight: 3 grants issued, rst asserted one cycle after the last grant → no rsp_valid pulses after the reset edge, busy=0 after the edge, pipeline empty; a subsequent req1-only access returns correctly after 4 cycles.
- Latency sweep: repeat the single-access test with ROM_LAT=1 and ROM_LAT=4 → rsp_valid at exactly N+3 and N+6 respectively.

Source files
------------

// File: rtl/font_rom_arbiter_if.sv
// ============================================================================
// Module   : font_rom_arbiter_if
// Brief    : Requester, ROM and response signal bundle for font_rom_arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface font_rom_arbiter_if #(
    parameter int AW = 12,
    parameter int DW = 8
);
    logic          req0;
    logic [AW-1:0] addr0;
    logic          gnt0;
    logic          req1;
    logic [AW-1:0] addr1;
    logic          gnt1;
    logic          rom_en;
    logic [AW-1:0] rom_addr;
    logic [DW-1:0] rom_data;
    logic          rsp_valid0;
    logic          rsp_valid1;
    logic [DW-1:0] rsp_data;
    logic          busy;

    // Everything outside the arbiter: both requesters plus the ROM itself.
    modport master (
        output req0, addr0, req1, addr1, rom_data,
        input  gnt0, gnt1, rom_en, rom_addr, rsp_valid0, rsp_valid1, rsp_data, busy
    );

    modport slave (
        input  req0, addr0, req1, addr1, rom_data,
        output gnt0, gnt1, rom_en, rom_addr, rsp_valid0, rsp_valid1, rsp_data, busy
    );
endinterface

`default_nettype wire

// File: rtl/font_rom_arbiter.sv
// ============================================================================
// Module   : font_rom_arbiter
// Brief    : Round-robin sharing of one fixed-latency font ROM between two
//            text-overlay requesters, with a tagged response pipeline.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module font_rom_arbiter #(
    parameter int AW      = 12,
    parameter int DW      = 8,
    parameter int ROM_LAT = 1
) (
    input wire                clk,
    input wire                rst,
    font_rom_arbiter_if.slave bus
);

    generate
        if (ROM_LAT < 1) begin : g_lat_check
            $error("font_rom_arbiter: ROM_LAT must be >= 1");
        end
    endgenerate

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_any;
    logic          w_gid;
    logic [AW-1:0] w_gaddr;

    logic               r_last;
    logic               r_rom_en;
    logic [AW-1:0]      r_rom_addr;
    logic [ROM_LAT:0]   r_tag_vld;
    logic [ROM_LAT:0]   r_tag_id;
    logic               r_rsp_v0;
    logic               r_rsp_v1;
    logic [DW-1:0]      r_rsp_data;

    // On a tie the requester that was not served last wins.
    always_comb begin
        w_gnt0  = 1'b0;
        w_gnt1  = 1'b0;
        if (!rst) begin
            w_gnt0 = bus.req0 && (!bus.req1 || r_last);
            w_gnt1 = bus.req1 && (!bus.req0 || !r_last);
        end
        w_any   = w_gnt0 | w_gnt1;
        w_gid   = w_gnt1;
        w_gaddr = w_gnt1 ? bus.addr1 : bus.addr0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_last     <= 1'b1;
            r_rom_en   <= 1'b0;
            r_rom_addr <= '0;
            r_tag_vld  <= '0;
            r_tag_id   <= '0;
            r_rsp_v0   <= 1'b0;
            r_rsp_v1   <= 1'b0;
            r_rsp_data <= '0;
        end else begin
            if (w_any) begin
                r_last     <= w_gid;
                r_rom_addr <= w_gaddr;
            end
            r_rom_en  <= w_any;
            // Stage ROM_LAT lines up with rom_data for the access it tags.
            r_tag_vld <= {r_tag_vld[ROM_LAT-1:0], w_any};
            r_tag_id  <= {r_tag_id[ROM_LAT-1:0], w_gid};
            if (r_tag_vld[ROM_LAT]) begin
                r_rsp_data <= bus.rom_data;
                r_rsp_v0   <= !r_tag_id[ROM_LAT];
                r_rsp_v1   <= r_tag_id[ROM_LAT];
            end else begin
                r_rsp_v0   <= 1'b0;
                r_rsp_v1   <= 1'b0;
            end
        end
    end

    assign bus.gnt0       = w_gnt0;
    assign bus.gnt1       = w_gnt1;
    assign bus.rom_en     = r_rom_en;
    assign bus.rom_addr   = r_rom_addr;
    assign bus.rsp_valid0 = r_rsp_v0;
    assign bus.rsp_valid1 = r_rsp_v1;
    assign bus.rsp_data   = r_rsp_data;
    assign bus.busy       = r_rom_en | (|r_tag_vld);

endmodule

`default_nettype wire
